// File: rtl/control_unit_types_pkg.sv
// Decoder-side control encodings for the multiply/divide path.
package control_unit_types_pkg;

  localparam int MD_CYCLES = 32;

  typedef enum logic [2:0] {
    MD_NONE,
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU,
    MD_MFHI,
    MD_MFLO
  } mdop_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Core datapath types shared by the execute-side blocks.
package cpu_types_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL,
    ALU_SRL,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU
  } aluop_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning HI and LO.
//
// state   | meaning
// --------+-------------------------------------------------------------
// MD_IDLE | waiting for start; magnitudes and result signs latched on start
// MD_BUSY | one iteration per cycle; HI/LO written on the last iteration
module muldiv_unit
  import control_unit_types_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int MD_CYCLES = control_unit_types_pkg::MD_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  mdop_t             op,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              abort,
  output logic              busy,
  output logic              done_pulse,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo
);

  localparam int CNT_W = $clog2(MD_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MD_CYCLES - 1);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  md_state_t           state;
  logic [CNT_W-1:0]    cnt;
  logic [2*WORD_W-1:0] acc;
  logic [WORD_W-1:0]   mag_b;
  logic                is_div;
  logic                neg_q;
  logic                neg_r;
  logic                div_zero;

  logic                signed_op;
  logic [WORD_W-1:0]   abs_a;
  logic [WORD_W-1:0]   abs_b;
  logic [WORD_W:0]     mul_sum;
  logic [WORD_W:0]     rem_shift;
  logic [WORD_W:0]     rem_diff;
  logic                rem_ge;
  logic [2*WORD_W-1:0] acc_nxt;
  logic [2*WORD_W-1:0] prod;
  logic [WORD_W-1:0]   quo;
  logic [WORD_W-1:0]   rem;

  assign busy       = (state == MD_BUSY);
  assign done_pulse = (state == MD_BUSY) && (cnt == LAST);

  // Operand magnitudes for the issue cycle
  always_comb begin
    signed_op = (op == MD_MULT) || (op == MD_DIV);
    abs_a     = (signed_op && a[WORD_W-1]) ? (~a + 1'b1) : a;
    abs_b     = (signed_op && b[WORD_W-1]) ? (~b + 1'b1) : b;
  end

  // One iteration step plus sign fix-ups applied to the step's result
  always_comb begin
    mul_sum   = {1'b0, acc[2*WORD_W-1:WORD_W]} + (acc[0] ? {1'b0, mag_b} : '0);
    rem_shift = acc[2*WORD_W-1:WORD_W-1];
    rem_diff  = rem_shift - {1'b0, mag_b};
    rem_ge    = (rem_shift >= {1'b0, mag_b});
    if (is_div)
      acc_nxt = {(rem_ge ? rem_diff[WORD_W-1:0] : rem_shift[WORD_W-1:0]),
                 acc[WORD_W-2:0], rem_ge};
    else
      acc_nxt = {mul_sum, acc[WORD_W-1:1]};
    prod = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
    // A zero divisor leaves every trial subtract "successful", so the
    // remainder already equals the dividend; only the quotient is forced.
    quo  = div_zero ? '1
         : (neg_q ? (~acc_nxt[WORD_W-1:0] + 1'b1) : acc_nxt[WORD_W-1:0]);
    rem  = neg_r ? (~acc_nxt[2*WORD_W-1:WORD_W] + 1'b1) : acc_nxt[2*WORD_W-1:WORD_W];
  end

  // Control FSM, iteration registers and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      acc      <= '0;
      mag_b    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            acc      <= {{WORD_W{1'b0}}, abs_a};
            mag_b    <= abs_b;
            is_div   <= (op == MD_DIV) || (op == MD_DIVU);
            neg_q    <= signed_op && (a[WORD_W-1] ^ b[WORD_W-1]);
            neg_r    <= signed_op && a[WORD_W-1];
            div_zero <= (b == '0);
            cnt      <= '0;
            state    <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          if (abort) begin
            state <= MD_IDLE;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state <= MD_IDLE;
              if (is_div) begin
                hi <= rem;
                lo <= quo;
              end else begin
                {hi, lo} <= prod;
              end
            end
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_muldiv_stage.sv
// Execute stage: single-cycle ALU, iterative mult/div with HI/LO, EX/MEM latch.
module ex_muldiv_stage
  import cpu_types_pkg::*;
  import control_unit_types_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int MD_CYCLES = control_unit_types_pkg::MD_CYCLES
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  aluop_t            aluop,
  input  mdop_t             mdop,
  input  logic              alusrc,
  input  logic              extop,
  input  logic [WORD_W-1:0] busA,
  input  logic [WORD_W-1:0] busB,
  input  logic [15:0]       imm,
  input  logic [4:0]        shamt,
  input  regbits_t          wsel,
  input  logic              regwen,
  input  logic              dwen,
  input  logic              dren,
  input  logic              halt,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              ex_stall,
  output logic              exm_valid,
  output logic              exm_regwen,
  output logic              exm_dwen,
  output logic              exm_dren,
  output logic              exm_halt,
  output logic [WORD_W-1:0] exm_result,
  output logic [WORD_W-1:0] exm_store,
  output regbits_t          exm_wsel
);

  logic              md_op;
  logic              md_start;
  logic              md_busy;
  logic              md_done_pulse;
  logic              md_done;
  logic [WORD_W-1:0] hi;
  logic [WORD_W-1:0] lo;
  logic [WORD_W-1:0] imm_ext;
  logic [WORD_W-1:0] opb;
  logic [WORD_W-1:0] alu_out;
  logic [WORD_W-1:0] result;

  assign md_op    = (mdop == MD_MULT) || (mdop == MD_MULTU) ||
                    (mdop == MD_DIV)  || (mdop == MD_DIVU);
  // md_done keeps a finished mult/div from restarting while it waits to advance
  assign md_start = in_valid && md_op && !md_done && !flush && !md_busy;
  assign ex_stall = md_start || md_busy;

  muldiv_unit #(
    .WORD_W    (WORD_W),
    .MD_CYCLES (MD_CYCLES)
  ) u_muldiv (
    .clk        (CLK),
    .rst        (RST),
    .start      (md_start),
    .op         (mdop),
    .a          (busA),
    .b          (busB),
    .abort      (flush),
    .busy       (md_busy),
    .done_pulse (md_done_pulse),
    .hi         (hi),
    .lo         (lo)
  );

  // Operand selection, ALU, and HI/LO read mux
  always_comb begin
    imm_ext = extop ? {{(WORD_W-16){imm[15]}}, imm} : {{(WORD_W-16){1'b0}}, imm};
    opb     = alusrc ? imm_ext : busB;
    case (aluop)
      ALU_SLL:  alu_out = opb << shamt;
      ALU_SRL:  alu_out = opb >> shamt;
      ALU_ADD:  alu_out = busA + opb;
      ALU_SUB:  alu_out = busA - opb;
      ALU_AND:  alu_out = busA & opb;
      ALU_OR:   alu_out = busA | opb;
      ALU_XOR:  alu_out = busA ^ opb;
      ALU_NOR:  alu_out = ~(busA | opb);
      ALU_SLT:  alu_out = {{(WORD_W-1){1'b0}}, ($signed(busA) < $signed(opb))};
      ALU_SLTU: alu_out = {{(WORD_W-1){1'b0}}, (busA < opb)};
      default:  alu_out = '0;
    endcase
    if (mdop == MD_MFHI)
      result = hi;
    else if (mdop == MD_MFLO)
      result = lo;
    else
      result = alu_out;
  end

  // Sticky completion flag, cleared when the finished instruction advances
  always_ff @(posedge CLK) begin
    if (RST)
      md_done <= 1'b0;
    else if (flush)
      md_done <= 1'b0;
    else if (md_done_pulse)
      md_done <= 1'b1;
    else if (in_valid && !ex_stall && !mem_stall)
      md_done <= 1'b0;
  end

  // EX/MEM latch: reset, flush bubble, mem hold, stall bubble, capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      exm_valid  <= 1'b0;
      exm_regwen <= 1'b0;
      exm_dwen   <= 1'b0;
      exm_dren   <= 1'b0;
      exm_halt   <= 1'b0;
      exm_result <= '0;
      exm_store  <= '0;
      exm_wsel   <= '0;
    end else if (flush || (ex_stall && !mem_stall)) begin
      exm_valid  <= 1'b0;
      exm_regwen <= 1'b0;
      exm_dwen   <= 1'b0;
      exm_dren   <= 1'b0;
      exm_halt   <= 1'b0;
    end else if (!mem_stall) begin
      exm_valid  <= in_valid;
      // mult/div only write HI/LO, never the register file
      exm_regwen <= in_valid && regwen && !md_op;
      exm_dwen   <= in_valid && dwen;
      exm_dren   <= in_valid && dren;
      exm_halt   <= in_valid && halt;
      exm_result <= result;
      exm_store  <= busB;
      exm_wsel   <= wsel;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Directed self-checking bench for ex_muldiv_stage.
module tb_ex_muldiv_stage;
  import cpu_types_pkg::*;
  import control_unit_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  aluop_t      aluop;
  mdop_t       mdop;
  logic        alusrc, extop;
  logic [31:0] busA, busB;
  logic [15:0] imm;
  logic [4:0]  shamt;
  regbits_t    wsel;
  logic        regwen, dwen, dren, halt;
  logic        mem_stall, flush;
  logic        ex_stall;
  logic        exm_valid, exm_regwen, exm_dwen, exm_dren, exm_halt;
  logic [31:0] exm_result, exm_store;
  regbits_t    exm_wsel;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    aluop_t      op;
    logic        alusrc;
    logic        extop;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs [$];

  always #5 CLK = ~CLK;

  ex_muldiv_stage dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .aluop(aluop), .mdop(mdop),
    .alusrc(alusrc), .extop(extop), .busA(busA), .busB(busB), .imm(imm),
    .shamt(shamt), .wsel(wsel), .regwen(regwen), .dwen(dwen), .dren(dren),
    .halt(halt), .mem_stall(mem_stall), .flush(flush), .ex_stall(ex_stall),
    .exm_valid(exm_valid), .exm_regwen(exm_regwen), .exm_dwen(exm_dwen),
    .exm_dren(exm_dren), .exm_halt(exm_halt), .exm_result(exm_result),
    .exm_store(exm_store), .exm_wsel(exm_wsel)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; aluop = ALU_ADD; mdop = MD_NONE; alusrc = 1'b0; extop = 1'b0;
    busA = '0; busB = '0; imm = '0; shamt = '0; wsel = '0;
    regwen = 1'b0; dwen = 1'b0; dren = 1'b0; halt = 1'b0;
  endtask

  task automatic drive(input aluop_t op, input mdop_t md, input logic src, input logic ext,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] im,
                       input logic [4:0] sh, input logic [4:0] ws);
    in_valid = 1'b1; aluop = op; mdop = md; alusrc = src; extop = ext;
    busA = a; busB = b; imm = im; shamt = sh; wsel = ws;
    regwen = 1'b1; dwen = 1'b0; dren = 1'b0; halt = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1; flush = 1'b0; mem_stall = 1'b0;
    idle_inputs();
    tick(); tick();
    RST = 1'b0;
  endtask

  // Issue a mult/div, count stall cycles, then read HI and LO back via MFHI/MFLO
  task automatic run_md(input string tag, input mdop_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    drive(ALU_ADD, op, 1'b0, 1'b0, a, b, 16'h0, 5'd0, 5'd3);
    n = 0;
    #1;
    while (ex_stall && n < 100) begin
      tick();
      n++;
    end
    chk({tag, " stall_len"}, n, 33);
    tick();
    chk({tag, " adv_valid"}, {31'b0, exm_valid}, 32'd1);
    chk({tag, " adv_regwen"}, {31'b0, exm_regwen}, 32'd0);
    drive(ALU_ADD, MD_MFHI, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 5'd0, 5'd4);
    tick();
    chk({tag, " hi"}, exm_result, exp_hi);
    drive(ALU_ADD, MD_MFLO, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 5'd0, 5'd5);
    tick();
    chk({tag, " lo"}, exm_result, exp_lo);
    idle_inputs();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{ALU_SUB,  1'b0, 1'b0, 32'd3,        32'd5,        16'h0,    5'd0,  32'hFFFFFFFE});
    vecs.push_back('{ALU_SLL,  1'b0, 1'b0, 32'd0,        32'd1,        16'h0,    5'd4,  32'd16});
    vecs.push_back('{ALU_SRL,  1'b0, 1'b0, 32'd0,        32'h80000000, 16'h0,    5'd31, 32'd1});
    vecs.push_back('{ALU_AND,  1'b0, 1'b0, 32'h0000F0F0, 32'h0000FF00, 16'h0,    5'd0,  32'h0000F000});
    vecs.push_back('{ALU_OR,   1'b0, 1'b0, 32'h000000F0, 32'h0000000F, 16'h0,    5'd0,  32'h000000FF});
    vecs.push_back('{ALU_XOR,  1'b0, 1'b0, 32'h000000FF, 32'h0000000F, 16'h0,    5'd0,  32'h000000F0});
    vecs.push_back('{ALU_NOR,  1'b0, 1'b0, 32'd0,        32'd0,        16'h0,    5'd0,  32'hFFFFFFFF});
    vecs.push_back('{ALU_SLT,  1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        16'h0,    5'd0,  32'd1});
    vecs.push_back('{ALU_SLTU, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        16'h0,    5'd0,  32'd0});
    vecs.push_back('{ALU_ADD,  1'b1, 1'b0, 32'd1,        32'd0,        16'hFFFF, 5'd0,  32'h00010000});
    vecs.push_back('{ALU_ADD,  1'b0, 1'b0, 32'hFFFFFFFF, 32'd1,        16'h0,    5'd0,  32'd0});

    do_reset();
    chk("rst exm_valid",  {31'b0, exm_valid},  32'd0);
    chk("rst exm_regwen", {31'b0, exm_regwen}, 32'd0);
    chk("rst exm_result", exm_result, 32'd0);
    chk("rst ex_stall",   {31'b0, ex_stall},   32'd0);

    // Flush of a mult in flight with HI=LO=0
    drive(ALU_ADD, MD_MULT, 1'b0, 1'b0, 32'd5, 32'd5, 16'h0, 5'd0, 5'd2);
    for (int i = 0; i < 11; i++) tick();
    flush = 1'b1;
    #1;
    chk("flush stall_before", {31'b0, ex_stall}, 32'd1);
    tick();
    flush = 1'b0;
    idle_inputs();
    #1;
    chk("flush stall_after", {31'b0, ex_stall}, 32'd0);
    chk("flush exm_valid", {31'b0, exm_valid}, 32'd0);
    drive(ALU_ADD, MD_MFHI, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 5'd0, 5'd4);
    tick();
    chk("flush hi", exm_result, 32'd0);
    drive(ALU_ADD, MD_MFLO, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 5'd0, 5'd5);
    tick();
    chk("flush lo", exm_result, 32'd0);
    idle_inputs();
    tick();

    // ADD with sign-extended immediate
    drive(ALU_ADD, MD_NONE, 1'b1, 1'b1, 32'd5, 32'd0, 16'hFFFF, 5'd0, 5'd9);
    tick();
    chk("addi result", exm_result, 32'd4);
    chk("addi regwen", {31'b0, exm_regwen}, 32'd1);
    chk("addi valid",  {31'b0, exm_valid},  32'd1);
    chk("addi wsel",   {27'b0, exm_wsel},   32'd9);

    foreach (vecs[i]) begin
      drive(vecs[i].op, MD_NONE, vecs[i].alusrc, vecs[i].extop, vecs[i].a, vecs[i].b,
            vecs[i].imm, vecs[i].shamt, 5'd1);
      tick();
      chk($sformatf("alu vec%0d", i), exm_result, vecs[i].exp);
    end
    idle_inputs();
    tick();
    chk("bubble valid", {31'b0, exm_valid}, 32'd0);

    run_md("mult",  MD_MULT, 32'hFFFFFFFD, 32'd7,  32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md("divu",  MD_DIVU, 32'd100,      32'd7,  32'd2,        32'd14);
    run_md("div",   MD_DIV,  32'hFFFFFFF9, 32'd2,  32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("divu0", MD_DIVU, 32'd9,        32'd0,  32'd9,        32'hFFFFFFFF);

    // mem_stall spanning the final iteration: HI/LO still written, advance waits
    drive(ALU_ADD, MD_MULTU, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2, 16'h0, 5'd0, 5'd6);
    for (int i = 0; i < 30; i++) tick();
    mem_stall = 1'b1;
    tick(); tick(); tick();
    chk("mstall md stall_low", {31'b0, ex_stall}, 32'd0);
    tick();
    chk("mstall md held", {31'b0, exm_valid}, 32'd0);
    mem_stall = 1'b0;
    tick();
    chk("mstall md valid",  {31'b0, exm_valid},  32'd1);
    chk("mstall md regwen", {31'b0, exm_regwen}, 32'd0);
    drive(ALU_ADD, MD_MFLO, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 5'd0, 5'd5);
    tick();
    chk("multu lo", exm_result, 32'hFFFFFFFE);
    drive(ALU_ADD, MD_MFHI, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 5'd0, 5'd4);
    tick();
    chk("multu hi", exm_result, 32'd1);

    // SLT capture, then mem_stall freezes the latch for three cycles
    drive(ALU_SLT, MD_NONE, 1'b0, 1'b0, 32'd3, 32'd9, 16'h0, 5'd0, 5'd7);
    tick();
    chk("slt result", exm_result, 32'd1);
    chk("slt wsel", {27'b0, exm_wsel}, 32'd7);
    mem_stall = 1'b1;
    drive(ALU_ADD, MD_NONE, 1'b0, 1'b0, 32'd10, 32'd20, 16'h0, 5'd0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mstall result c%0d", i), exm_result, 32'd1);
      chk($sformatf("mstall wsel c%0d", i), {27'b0, exm_wsel}, 32'd7);
    end
    mem_stall = 1'b0;
    tick();
    chk("release result", exm_result, 32'd30);
    chk("release wsel", {27'b0, exm_wsel}, 32'd9);
    chk("release store", exm_store, 32'd20);
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
